// File: rtl/cdr_pi_override_ctrl_if.sv
// Signal bundle between cdr_pi_override_ctrl and its neighbours.
// Defining CDR_OVR_CNT_EN adds the override-counter signals ovr_cnt / ovr_cnt_clr.
interface cdr_pi_override_ctrl_if #(
  parameter int NCH  = 4,
  parameter int NPI  = 8,
  parameter int NADC = 8
);
  logic [NCH-1:0]     sel_ext_pi;
  logic [NCH*NPI-1:0] pi_ctl_ext;
  logic [NCH*NPI-1:0] pi_ctl_int;
  logic               sel_ext_pd_offset;
  logic [NADC-1:0]    pd_offset_ext;
  logic [NADC-1:0]    pd_offset_int;
  logic [NCH*NPI-1:0] pi_ctl_out;
  logic [NADC-1:0]    pd_offset_out;
  logic [NCH-1:0]     pi_settled;
  logic [NCH-1:0]     pi_slewing;
`ifdef CDR_OVR_CNT_EN
  logic [NCH*8-1:0]   ovr_cnt;
  logic               ovr_cnt_clr;

  modport master (
    output sel_ext_pi, pi_ctl_ext, pi_ctl_int, sel_ext_pd_offset,
           pd_offset_ext, pd_offset_int, ovr_cnt_clr,
    input  pi_ctl_out, pd_offset_out, pi_settled, pi_slewing, ovr_cnt
  );
  modport slave (
    input  sel_ext_pi, pi_ctl_ext, pi_ctl_int, sel_ext_pd_offset,
           pd_offset_ext, pd_offset_int, ovr_cnt_clr,
    output pi_ctl_out, pd_offset_out, pi_settled, pi_slewing, ovr_cnt
  );
`else
  modport master (
    output sel_ext_pi, pi_ctl_ext, pi_ctl_int, sel_ext_pd_offset,
           pd_offset_ext, pd_offset_int,
    input  pi_ctl_out, pd_offset_out, pi_settled, pi_slewing
  );
  modport slave (
    input  sel_ext_pi, pi_ctl_ext, pi_ctl_int, sel_ext_pd_offset,
           pd_offset_ext, pd_offset_int,
    output pi_ctl_out, pd_offset_out, pi_settled, pi_slewing
  );
`endif
endinterface

// File: rtl/cdr_pi_override_ctrl.sv
// Per-channel CDR/JTAG PI code override with shortest-path one-LSB slewing, plus PD offset mux.
// Optional CDR_OVR_CNT_EN: per-channel saturating count of completed slews onto the external code.
module cdr_pi_override_ctrl #(
  parameter int NCH      = 4,
  parameter int NPI      = 8,
  parameter int NADC     = 8,
  parameter int STEP_DIV = 4
) (
  input logic                    clk,
  input logic                    rst,
  cdr_pi_override_ctrl_if.slave  bus
);
  localparam int DIVW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(STEP_DIV - 1);
  localparam logic [DIVW-1:0] DIV_ZERO = {DIVW{1'b0}};
  localparam logic [NPI-1:0]  ZERO     = {NPI{1'b0}};
  localparam logic [NPI-1:0]  ONE      = {{(NPI-1){1'b0}}, 1'b1};
  localparam logic [NPI-1:0]  ALL1     = {NPI{1'b1}};
  localparam logic [NPI-1:0]  HALF     = {1'b1, {(NPI-1){1'b0}}};

  typedef enum logic [1:0] {
    TRACK_INT = 2'd0,
    SLEW_EXT  = 2'd1,
    HOLD_EXT  = 2'd2,
    SLEW_INT  = 2'd3
  } state_t;

  // Half-range distance breaks the tie downward.
  function automatic logic [NPI-1:0] step_toward(input logic [NPI-1:0] cur, input logic [NPI-1:0] tgt);
    logic [NPI-1:0] d;
    d = tgt - cur;
    if (d == ZERO) step_toward = cur;
    else if (d < HALF) step_toward = cur + ONE;
    else step_toward = cur - ONE;
  endfunction

  function automatic logic within_one(input logic [NPI-1:0] cur, input logic [NPI-1:0] tgt);
    logic [NPI-1:0] d;
    d = tgt - cur;
    within_one = (d == ZERO) || (d == ONE) || (d == ALL1);
  endfunction

  logic [NCH-1:0]  sel_meta_r, sel_sync_r;
  logic            pd_meta_r, pd_sync_r;
  logic [NADC-1:0] pd_out_r;
  logic [NCH-1:0]  settled_r, slewing_r, settled_s;
  state_t          state_r [NCH];
  state_t          state_s [NCH];
  logic [NPI-1:0]  cur_r [NCH];
  logic [NPI-1:0]  cur_s [NCH];
  logic [DIVW-1:0] div_r [NCH];
  logic [DIVW-1:0] div_s [NCH];
  logic [NPI-1:0]  ext_code_s [NCH];
  logic [NPI-1:0]  int_code_s [NCH];

  // Per-channel next-state, next code and divider; a select change always beats a step.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ext_code_s[i] = bus.pi_ctl_ext[i*NPI +: NPI];
      int_code_s[i] = bus.pi_ctl_int[i*NPI +: NPI];
      state_s[i]    = state_r[i];
      cur_s[i]      = cur_r[i];
      div_s[i]      = div_r[i];
      case (state_r[i])
        TRACK_INT: begin
          cur_s[i] = int_code_s[i];
          div_s[i] = DIV_ZERO;
          if (sel_sync_r[i]) state_s[i] = SLEW_EXT;
          else state_s[i] = TRACK_INT;
        end
        SLEW_EXT: begin
          if (!sel_sync_r[i]) begin
            state_s[i] = SLEW_INT;
            div_s[i]   = DIV_ZERO;
          end else if (cur_r[i] == ext_code_s[i]) begin
            state_s[i] = HOLD_EXT;
            div_s[i]   = DIV_ZERO;
          end else if (div_r[i] == DIV_LAST) begin
            div_s[i] = DIV_ZERO;
            if (within_one(cur_r[i], ext_code_s[i])) begin
              cur_s[i]   = ext_code_s[i];
              state_s[i] = HOLD_EXT;
            end else begin
              cur_s[i] = step_toward(cur_r[i], ext_code_s[i]);
            end
          end else begin
            div_s[i] = div_r[i] + DIVW'(1);
          end
        end
        HOLD_EXT: begin
          div_s[i] = DIV_ZERO;
          if (!sel_sync_r[i]) state_s[i] = SLEW_INT;
          else if (cur_r[i] != ext_code_s[i]) state_s[i] = SLEW_EXT;
          else state_s[i] = HOLD_EXT;
        end
        SLEW_INT: begin
          if (sel_sync_r[i]) begin
            state_s[i] = SLEW_EXT;
            div_s[i]   = DIV_ZERO;
          end else if (cur_r[i] == int_code_s[i]) begin
            state_s[i] = TRACK_INT;
            div_s[i]   = DIV_ZERO;
          end else if (div_r[i] == DIV_LAST) begin
            div_s[i] = DIV_ZERO;
            if (within_one(cur_r[i], int_code_s[i])) begin
              cur_s[i]   = int_code_s[i];
              state_s[i] = TRACK_INT;
            end else begin
              cur_s[i] = step_toward(cur_r[i], int_code_s[i]);
            end
          end else begin
            div_s[i] = div_r[i] + DIVW'(1);
          end
        end
        default: begin
          state_s[i] = TRACK_INT;
          cur_s[i]   = ZERO;
          div_s[i]   = DIV_ZERO;
        end
      endcase
      settled_s[i] = (state_s[i] == TRACK_INT) || (state_s[i] == HOLD_EXT);
    end
  end

  // Synchronisers, channel state, status flags and PD offset register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_meta_r <= {NCH{1'b0}};
      sel_sync_r <= {NCH{1'b0}};
      pd_meta_r  <= 1'b0;
      pd_sync_r  <= 1'b0;
      pd_out_r   <= {NADC{1'b0}};
      settled_r  <= {NCH{1'b1}};
      slewing_r  <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= TRACK_INT;
        cur_r[i]   <= ZERO;
        div_r[i]   <= DIV_ZERO;
      end
    end else begin
      sel_meta_r <= bus.sel_ext_pi;
      sel_sync_r <= sel_meta_r;
      pd_meta_r  <= bus.sel_ext_pd_offset;
      pd_sync_r  <= pd_meta_r;
      pd_out_r   <= pd_sync_r ? bus.pd_offset_ext : bus.pd_offset_int;
      settled_r  <= settled_s;
      slewing_r  <= ~settled_s;
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= state_s[i];
        cur_r[i]   <= cur_s[i];
        div_r[i]   <= div_s[i];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign bus.pi_ctl_out[g*NPI +: NPI] = cur_r[g];
  end
  assign bus.pd_offset_out = pd_out_r;
  assign bus.pi_settled    = settled_r;
  assign bus.pi_slewing    = slewing_r;

`ifdef CDR_OVR_CNT_EN
  logic [7:0] cnt_r [NCH];

  // Count completed slews onto the external code; clear has priority, saturate at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt_r[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.ovr_cnt_clr) cnt_r[i] <= 8'd0;
        else if ((state_r[i] == SLEW_EXT) && (state_s[i] == HOLD_EXT) && (cnt_r[i] != 8'hFF))
          cnt_r[i] <= cnt_r[i] + 8'd1;
        else cnt_r[i] <= cnt_r[i];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    assign bus.ovr_cnt[g*8 +: 8] = cnt_r[g];
  end
`endif
endmodule
